// File: rtl/sipo_deserializer_pkg.sv
// Shared types and sizing helpers for the SIPO deserializer.
// Optional even-parity bit support is enabled by defining SIPO_PARITY_EN.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_t;

    localparam int unsigned SIPO_WIDTH = 8;

    // Bit counter must be able to hold WIDTH+1 (data bits plus a parity bit).
    function automatic int unsigned sipo_cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bundle between a bit source, the deserializer and its consumer.
// Optional even-parity bit support is enabled by defining SIPO_PARITY_EN.
interface sipo_deserializer_if
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
);

    logic             serial_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             frame_err;
    logic             parity_err;

    modport master (
        output serial_in,
        output bit_valid,
        output frame_start,
        output out_ready,
        input  parallel_out,
        input  out_valid,
        input  overrun,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  serial_in,
        input  bit_valid,
        input  frame_start,
        input  out_ready,
        output parallel_out,
        output out_valid,
        output overrun,
        output frame_err,
        output parity_err
    );

endinterface

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel deserializer with valid/ready output, framing and overrun flags.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit after each word.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    sipo_deserializer_if.slave bus
);

    localparam int unsigned   CW        = sipo_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

    sipo_state_t      r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frame_err;

    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_word;
    logic             w_restart;
    logic             w_complete;
    logic             w_accept_new;

    assign w_shift_next = {r_shift[WIDTH-2:0], bus.serial_in};
    assign w_restart    = bus.bit_valid && bus.frame_start;
    assign w_accept_new = !r_valid || bus.out_ready;

`ifdef SIPO_PARITY_EN
    logic r_parity_err;
    logic w_word_perr;

    // The parity bit is not shifted in, so the held shift register is the word.
    always_comb begin
        w_complete  = 1'b0;
        w_word      = r_shift;
        w_word_perr = ^{r_shift, bus.serial_in};
        if (bus.bit_valid && !bus.frame_start && (r_state == PARITY)) begin
            w_complete = 1'b1;
        end
    end
`else
    always_comb begin
        w_complete = 1'b0;
        w_word     = w_shift_next;
        if (bus.bit_valid && !bus.frame_start && (r_state == SHIFT)
            && (r_count == LAST_DATA)) begin
            w_complete = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            if (r_valid && bus.out_ready) begin
                r_valid <= 1'b0;
            end

            // A framed bit always restarts; it is an error only if a word was in flight.
            if (w_restart) begin
                r_frame_err <= (r_state != IDLE);
                r_shift     <= w_shift_next;
                r_count     <= CW'(1);
                r_state     <= SHIFT;
            end else if (bus.bit_valid) begin
                case (r_state)
                    SHIFT: begin
                        r_shift <= w_shift_next;
                        if (r_count == LAST_DATA) begin
`ifdef SIPO_PARITY_EN
                            r_count <= r_count + CW'(1);
                            r_state <= PARITY;
`else
                            r_count <= '0;
                            r_state <= IDLE;
`endif
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                    PARITY: begin
                        r_count <= '0;
                        r_state <= IDLE;
                    end
                    default: ;
                endcase
            end

            if (w_complete) begin
                if (w_accept_new) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                    r_parity_err <= w_word_perr;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign bus.parallel_out = r_data;
    assign bus.out_valid    = r_valid;
    assign bus.overrun      = r_overrun;
    assign bus.frame_err    = r_frame_err;
`ifdef SIPO_PARITY_EN
    assign bus.parity_err   = r_parity_err;
`else
    assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed cases plus randomized traffic
// checked every cycle against a bit-queue model. Honours SIPO_PARITY_EN.
module tb_sipo_deserializer;

    localparam int unsigned W = 8;
`ifdef SIPO_PARITY_EN
    localparam int unsigned NBITS = W + 1;
`else
    localparam int unsigned NBITS = W;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(W)) bus_if ();

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int tests     = 0;
    int fails     = 0;
    int ferr_seen = 0;
    bit chk_en    = 1'b0;
    bit rnd_ready = 1'b0;

    // Model: collected bits live in a queue; a word is whatever NBITS bits follow a framed bit.
    bit           m_q[$];
    bit           m_busy  = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic         m_valid = 1'b0;
    logic         m_over  = 1'b0;
    logic         m_ferr  = 1'b0;
    logic         m_perr  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit           old_valid;
        logic [W-1:0] word;
        bit           px;
        if (reset) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_data  = '0;
            m_valid = 1'b0;
            m_over  = 1'b0;
            m_ferr  = 1'b0;
            m_perr  = 1'b0;
        end else begin
            old_valid = m_valid;
            m_ferr    = 1'b0;
            if (m_valid && bus_if.out_ready) m_valid = 1'b0;
            if (bus_if.bit_valid) begin
                if (bus_if.frame_start) begin
                    m_ferr = m_busy;
                    m_q.delete();
                    m_q.push_back(bus_if.serial_in);
                    m_busy = 1'b1;
                end else if (m_busy) begin
                    m_q.push_back(bus_if.serial_in);
                end
                if (m_busy && m_q.size() == NBITS) begin
                    word = '0;
                    px   = 1'b0;
                    for (int i = 0; i < W; i++) word[W-1-i] = m_q[i];
                    foreach (m_q[i]) px ^= m_q[i];
                    m_q.delete();
                    m_busy = 1'b0;
                    if (!old_valid || bus_if.out_ready) begin
                        m_data  = word;
                        m_valid = 1'b1;
`ifdef SIPO_PARITY_EN
                        m_perr  = px;
`endif
                    end else begin
                        m_over = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("parallel_out", bus_if.parallel_out, m_data);
            chk("out_valid",    bus_if.out_valid,    m_valid);
            chk("overrun",      bus_if.overrun,      m_over);
            chk("frame_err",    bus_if.frame_err,    m_ferr);
            chk("parity_err",   bus_if.parity_err,   m_perr);
            if (bus_if.frame_err === 1'b1) ferr_seen++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        if (rnd_ready) bus_if.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input bit bv, input bit fs, input bit b);
        bus_if.bit_valid   = bv;
        bus_if.frame_start = fs;
        bus_if.serial_in   = b;
        step();
        bus_if.bit_valid   = 1'b0;
        bus_if.frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) drive(1'b0, 1'b0, 1'b0);
            drive(1'b1, i == 0, w[W-1-i]);
        end
    endtask

    task automatic send_parity(input bit pbit);
`ifdef SIPO_PARITY_EN
        drive(1'b1, 1'b0, pbit);
`else
        if (pbit) begin end
`endif
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap);
        send_bits(w, W, gap);
        send_parity(^w);
    endtask

    initial begin
        logic [W-1:0] rw;
        int           f0;
        int           r;
        bus_if.serial_in   = 1'b0;
        bus_if.bit_valid   = 1'b0;
        bus_if.frame_start = 1'b0;
        bus_if.out_ready   = 1'b1;
        chk_en = 1'b1;

        repeat (3) step();
        chk("rst_parallel_out", bus_if.parallel_out, 32'h0);
        chk("rst_out_valid",    bus_if.out_valid,    32'h0);
        chk("rst_overrun",      bus_if.overrun,      32'h0);
        chk("rst_parity_err",   bus_if.parity_err,   32'h0);
        reset = 1'b0;

        // 0xA5 on consecutive edges; out_valid only after the final bit
        send_bits(8'hA5, W - 1, 0);
        chk("a5_valid_early", bus_if.out_valid, 32'h0);
        drive(1'b1, 1'b0, 1'b1);
`ifdef SIPO_PARITY_EN
        chk("a5_valid_before_par", bus_if.out_valid, 32'h0);
        send_parity(1'b0);
`endif
        chk("a5_data",    bus_if.parallel_out, 32'hA5);
        chk("a5_valid",   bus_if.out_valid,    32'h1);
        chk("a5_overrun", bus_if.overrun,      32'h0);
        chk("model_a5",   m_data,              32'hA5);
        drive(1'b0, 1'b0, 1'b0);
        chk("a5_consumed", bus_if.out_valid, 32'h0);

        // Same word with 3 idle cycles between bits
        f0 = ferr_seen;
        send_word(8'hA5, 3);
        chk("gap_data",   bus_if.parallel_out, 32'hA5);
        chk("gap_valid",  bus_if.out_valid,    32'h1);
        chk("gap_no_ferr", 32'(ferr_seen - f0), 32'h0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);

        // Overrun: consumer stalled across two back-to-back words
        bus_if.out_ready = 1'b0;
        send_word(8'h3C, 0);
        send_word(8'hC3, 0);
        chk("ovr_data",    bus_if.parallel_out, 32'h3C);
        chk("ovr_valid",   bus_if.out_valid,    32'h1);
        chk("ovr_flag",    bus_if.overrun,      32'h1);
        chk("model_ovr",   m_over,              32'h1);
        bus_if.out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("ovr_drained", bus_if.out_valid,    32'h0);
        chk("ovr_hold",    bus_if.parallel_out, 32'h3C);
        chk("ovr_sticky",  bus_if.overrun,      32'h1);

        // Frame restart mid-word
        f0 = ferr_seen;
        send_bits(8'hFF, 4, 0);
        send_word(8'h81, 0);
        chk("ferr_count", 32'(ferr_seen - f0), 32'h1);
        chk("ferr_data",  bus_if.parallel_out, 32'h81);
        drive(1'b0, 1'b0, 1'b0);

        // Reset mid-word
        send_bits(8'h55, 5, 0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rstmid_valid",   bus_if.out_valid,    32'h0);
        chk("rstmid_overrun", bus_if.overrun,      32'h0);
        chk("rstmid_data",    bus_if.parallel_out, 32'h0);
        send_bits(8'h0F, W - 1, 0);
        chk("rstmid_valid_early", bus_if.out_valid, 32'h0);
        drive(1'b1, 1'b0, 1'b1);
        send_parity(1'b0);
        chk("rstmid_new_data",  bus_if.parallel_out, 32'h0F);
        chk("rstmid_new_valid", bus_if.out_valid,    32'h1);
        chk("rstmid_new_ovr",   bus_if.overrun,      32'h0);
        drive(1'b0, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
        send_bits(8'h07, W, 0);
        chk("par_valid_early", bus_if.out_valid, 32'h0);
        drive(1'b1, 1'b0, 1'b1);
        chk("par_ok_valid", bus_if.out_valid,  32'h1);
        chk("par_ok_err",   bus_if.parity_err, 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        send_bits(8'h07, W, 0);
        drive(1'b1, 1'b0, 1'b0);
        chk("par_bad_data", bus_if.parallel_out, 32'h07);
        chk("par_bad_err",  bus_if.parity_err,   32'h1);
        chk("model_perr",   m_perr,              32'h1);
        drive(1'b0, 1'b0, 1'b0);
`endif

        // Randomized traffic with a toggling consumer, aborts, noise and resets
        rnd_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 99));
            rw = W'($urandom);
            if (r < 4) begin
                reset = 1'b1;
                drive(1'b0, 1'b0, 1'b0);
                reset = 1'b0;
            end else if (r < 14) begin
                send_bits(rw, int'($urandom_range(1, NBITS - 1)), int'($urandom_range(0, 2)));
            end else if (r < 20) begin
                drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                send_bits(rw, W, int'($urandom_range(0, 2)));
                send_parity(($urandom_range(0, 9) < 7) ? ^rw : ~^rw);
            end
            repeat ($urandom_range(0, 2))
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rnd_ready = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
